// File: rtl/forwarding_ctrl.sv
// Operand-forwarding and load-use hazard controller: tracks in-flight destinations in a
// shadow pipe (EX/MEM/WB/RET) and produces registered EX operand-mux selects plus stall/bubble.
module forwarding_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_we_i,
  input  logic                  id_load_i,
  output logic [2:0]            fwd_rs1_sel_o,
  output logic [2:0]            fwd_rs2_sel_o,
  output logic                  stall_id_o,
  output logic                  bubble_ex_o,
  output logic [0:0]            dbg_state_o,
  output logic [REG_ADDR_W+2:0] dbg_ret_o
);

  // Handshake: none; every non-hold cycle is an advance, hold_i freezes all state.
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_LU_STALL = 1'b1;

  localparam logic [2:0] SEL_REG      = 3'd0;
  localparam logic [2:0] SEL_MEM_ALU  = 3'd1;
  localparam logic [2:0] SEL_WB_ALU   = 3'd2;
  localparam logic [2:0] SEL_WB_LOAD  = 3'd3;
  localparam logic [2:0] SEL_RET      = 3'd4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  load;
  } slot_t;

  slot_t ex_q, mem_q, wb_q, ret_q, id_ent;
  logic [0:0] state_q, state_nxt;
  logic [2:0] sel1_nxt, sel2_nxt;
  logic       lu_hit, adv_valid;

  function automatic logic hit(slot_t s, logic [REG_ADDR_W-1:0] rs);
    return s.valid & s.we & (s.rd == rs) & (rs != '0);
  endfunction

  // Youngest producer wins; an EX load match never advances (it stalls), hence SEL_REG.
  function automatic logic [2:0] sel_for(slot_t ex, slot_t mem, slot_t wb,
                                         logic [REG_ADDR_W-1:0] rs);
    logic [2:0] sel;
    sel = SEL_REG;
    if (hit(ex, rs))       sel = ex.load ? SEL_REG : SEL_MEM_ALU;
    else if (hit(mem, rs)) sel = mem.load ? SEL_WB_LOAD : SEL_WB_ALU;
    else if (hit(wb, rs))  sel = SEL_RET;
    return sel;
  endfunction

  always_comb begin
    lu_hit = id_valid_i & ex_q.valid & ex_q.we & ex_q.load & (ex_q.rd != '0) &
             ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i)) & ~flush_i;
    adv_valid = id_valid_i & ~lu_hit & ~flush_i;

    id_ent.valid = adv_valid;
    id_ent.rd    = id_rd_i;
    id_ent.we    = id_reg_we_i;
    id_ent.load  = id_load_i;

    // Bubbles carry no operands, so their selects are forced to the regfile path.
    sel1_nxt = adv_valid ? sel_for(ex_q, mem_q, wb_q, id_rs1_i) : SEL_REG;
    sel2_nxt = adv_valid ? sel_for(ex_q, mem_q, wb_q, id_rs2_i) : SEL_REG;

    state_nxt = ST_RUN;
    if (state_q == ST_RUN && lu_hit) state_nxt = ST_LU_STALL;
  end

  assign stall_id_o  = lu_hit & arstn_i;
  assign bubble_ex_o = (lu_hit | flush_i) & arstn_i;
  assign dbg_state_o = state_q;
  assign dbg_ret_o   = ret_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      ret_q         <= '0;
      state_q       <= ST_RUN;
      fwd_rs1_sel_o <= SEL_REG;
      fwd_rs2_sel_o <= SEL_REG;
    end else if (!hold_i) begin
      ex_q          <= id_ent;
      mem_q         <= ex_q;
      wb_q          <= mem_q;
      ret_q         <= wb_q;
      state_q       <= state_nxt;
      fwd_rs1_sel_o <= sel1_nxt;
      fwd_rs2_sel_o <= sel2_nxt;
    end
  end

endmodule

// File: tb/tb_forwarding_ctrl.sv
// Self-checking bench for forwarding_ctrl: directed hazard scenarios plus random traffic,
// checked against an age-ordered queue model of in-flight writers.
module tb_forwarding_ctrl;

  logic       clk_i = 1'b0;
  logic       arstn_i, hold_i, flush_i, id_valid_i, id_reg_we_i, id_load_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0] fwd_rs1_sel_o, fwd_rs2_sel_o;
  logic       stall_id_o, bubble_ex_o;
  logic [0:0] dbg_state_o;
  logic [7:0] dbg_ret_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  forwarding_ctrl #(.REG_ADDR_W(5)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_reg_we_i(id_reg_we_i), .id_load_i(id_load_i),
    .fwd_rs1_sel_o(fwd_rs1_sel_o), .fwd_rs2_sel_o(fwd_rs2_sel_o),
    .stall_id_o(stall_id_o), .bubble_ex_o(bubble_ex_o),
    .dbg_state_o(dbg_state_o), .dbg_ret_o(dbg_ret_o)
  );

  // Reference model: pipe_q[0] is the youngest in-flight instruction (EX), [3] is RET.
  typedef struct packed {bit v; bit [4:0] rd; bit we; bit ld;} ent_t;
  ent_t       pipe_q[$];
  logic [5:0] exp_q[$];
  bit         m_lu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z = '0;
    pipe_q = {z, z, z, z};
    exp_q  = {6'd0};
    m_lu   = 1'b0;
  endtask

  function automatic logic [2:0] m_sel(logic [4:0] rs);
    if (rs == 5'd0) return 3'd0;
    for (int a = 0; a < 3; a++)
      if (pipe_q[a].v && pipe_q[a].we && pipe_q[a].rd == rs) begin
        if (a == 0) return pipe_q[a].ld ? 3'd0 : 3'd1;
        if (a == 1) return pipe_q[a].ld ? 3'd3 : 3'd2;
        return 3'd4;
      end
    return 3'd0;
  endfunction

  function automatic bit m_stall();
    ent_t e;
    e = pipe_q[0];
    return id_valid_i && e.v && e.we && e.ld && e.rd != 5'd0 &&
           (e.rd == id_rs1_i || e.rd == id_rs2_i) && !flush_i;
  endfunction

  // One clock: drive ID just after posedge, check at negedge, then advance the model.
  task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] d, input logic we, input logic ld,
                      input logic fl, input logic hd);
    bit st, adv, nlu;
    logic [5:0] cur, nsel;
    ent_t e;
    id_valid_i = v; id_rs1_i = r1; id_rs2_i = r2; id_rd_i = d;
    id_reg_we_i = we; id_load_i = ld; flush_i = fl; hold_i = hd;
    @(negedge clk_i);
    st  = m_stall();
    cur = exp_q[$];
    check("rs1_sel", fwd_rs1_sel_o, cur[5:3]);
    check("rs2_sel", fwd_rs2_sel_o, cur[2:0]);
    check("stall", stall_id_o, st);
    check("bubble", bubble_ex_o, st | fl);
    check("state", dbg_state_o, m_lu);
    check("ret_valid", dbg_ret_o[7], pipe_q[3].v);
    adv  = v && !st && !fl;
    nsel = adv ? {m_sel(r1), m_sel(r2)} : 6'd0;
    e    = '{adv, d, we, ld};
    nlu  = !m_lu && st;
    @(posedge clk_i);
    #1;
    if (!hd) begin
      pipe_q.push_front(e);
      void'(pipe_q.pop_back());
      exp_q.push_back(nsel);
      if (exp_q.size() > 8) void'(exp_q.pop_front());
      m_lu = nlu;
    end
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic we, input logic ld);
    step(1'b1, r1, r2, d, we, ld, 1'b0, 1'b0);
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_step();
    step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
         1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0),
         1'($urandom_range(0, 7) == 0));
  endtask

  initial begin
    arstn_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0;
    id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0; id_reg_we_i = 1'b0; id_load_i = 1'b0;
    model_reset();
    #12;
    check("rst_rs1", fwd_rs1_sel_o, 0);
    check("rst_rs2", fwd_rs2_sel_o, 0);
    check("rst_stall", stall_id_o, 0);
    check("rst_bubble", bubble_ex_o, 0);
    check("rst_state", dbg_state_o, 0);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;

    // Back-to-back ALU dependency.
    issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
    check("b2b_rs1", fwd_rs1_sel_o, 1);
    check("b2b_rs2", fwd_rs2_sel_o, 1);

    // Load-use: one stall, then load data from WB.
    issue(5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
    issue(5'd7, 5'd1, 5'd8, 1'b1, 1'b0);
    check("lu_state", dbg_state_o, 1);
    check("lu_bubble_sel", fwd_rs1_sel_o, 0);
    issue(5'd7, 5'd1, 5'd8, 1'b1, 1'b0);
    check("lu_rs1", fwd_rs1_sel_o, 3);
    check("lu_rs2", fwd_rs2_sel_o, 0);
    check("lu_back_run", dbg_state_o, 0);

    // Two-apart and three-apart dependencies.
    issue(5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
    nop();
    issue(5'd0, 5'd9, 5'd10, 1'b1, 1'b0);
    check("wb_rs2", fwd_rs2_sel_o, 2);
    issue(5'd1, 5'd2, 5'd11, 1'b1, 1'b0);
    nop();
    nop();
    issue(5'd11, 5'd3, 5'd12, 1'b1, 1'b0);
    check("ret_rs1", fwd_rs1_sel_o, 4);

    // x0 destination never forwards.
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    issue(5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    check("x0_rs1", fwd_rs1_sel_o, 0);
    check("x0_rs2", fwd_rs2_sel_o, 0);

    // Flush beats a load-use stall.
    issue(5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
    step(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush_state", dbg_state_o, 0);
    check("flush_sel", fwd_rs1_sel_o, 0);

    // Hold five cycles in the middle of a load-use hazard.
    issue(5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(5'd7, 5'd1, 5'd8, 1'b1, 1'b0);
    issue(5'd7, 5'd1, 5'd8, 1'b1, 1'b0);
    check("hold_rs1", fwd_rs1_sel_o, 3);

    // Two writers of x5: youngest wins.
    issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
    check("young_rs1", fwd_rs1_sel_o, 1);
    check("young_rs2", fwd_rs2_sel_o, 1);

    for (int i = 0; i < 400; i++) rand_step();

    // Mid-stream reset, with a producer in flight and flush asserted.
    issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    id_valid_i = 1'b1; id_rs1_i = 5'd5; id_rs2_i = 5'd5; flush_i = 1'b1;
    #2;
    arstn_i = 1'b0;
    #1;
    check("mid_rst_rs1", fwd_rs1_sel_o, 0);
    check("mid_rst_rs2", fwd_rs2_sel_o, 0);
    check("mid_rst_stall", stall_id_o, 0);
    check("mid_rst_bubble", bubble_ex_o, 0);
    check("mid_rst_state", dbg_state_o, 0);
    check("mid_rst_ret", dbg_ret_o[7], 0);
    model_reset();
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
    check("post_rst_rs1", fwd_rs1_sel_o, 0);

    for (int i = 0; i < 400; i++) rand_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
